// File: rtl/mul_result_fifo.sv
// First-word-fall-through buffer for the FP32 multiplier result stream.
// The source cannot stall, so words arriving while full are dropped and counted.
module mul_result_fifo #(
    parameter int DEPTH      = 16,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           z,
    input  logic                  z_stb,
    output logic [31:0]           out_z,
    output logic                  out_z_stb,
    input  logic                  out_z_ack,
    output logic [LOG2_DEPTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [15:0]           drop_count,
    output logic                  nan_seen
);
    localparam logic [LOG2_DEPTH:0] FULL_LVL = (LOG2_DEPTH+1)'(DEPTH);

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic logic is_nan(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    endfunction

    logic [31:0]           mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wp_q, wp_d;
    logic [LOG2_DEPTH-1:0] rp_q, rp_d;
    logic [LOG2_DEPTH:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           drop_q, drop_d;
    logic                  nan_q, nan_d;
    logic                  push, pop, drop;

    assign full      = (level_q == FULL_LVL);
    assign empty     = (level_q == '0);
    assign out_z_stb = ~empty;
    assign out_z     = empty ? 32'h0 : mem_q[rp_q];
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_count = drop_q;
    assign nan_seen  = nan_q;

    // A pop frees the slot the incoming word needs, so full+pop still accepts.
    assign pop  = out_z_stb & out_z_ack;
    assign push = z_stb & (~full | pop);
    assign drop = z_stb & full & ~pop;

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        nan_d      = nan_q;
        if (push) begin
            wp_d = wp_q + 1'b1;
            if (is_nan(z)) nan_d = 1'b1;
        end
        if (pop) rp_d = rp_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            drop_d     = sat_inc16(drop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= 16'd0;
            nan_q      <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            nan_q      <= nan_d;
        end
    end

    // Storage is data only; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wp_q] <= z;
    end
endmodule

// File: tb/tb_mul_result_fifo.sv
// Bench for mul_result_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations and a random phase.
module tb_mul_result_fifo;
    localparam int DEPTH = 16;
    localparam int LOG2  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] z = 32'h0;
    logic        z_stb = 1'b0;
    logic        out_z_ack = 1'b0;
    logic [31:0] out_z;
    logic        out_z_stb;
    logic [LOG2:0] level;
    logic        full, empty, overflow, nan_seen;
    logic [15:0] drop_count;

    mul_result_fifo #(.DEPTH(DEPTH), .LOG2_DEPTH(LOG2)) dut (
        .clk(clk), .rst(rst), .z(z), .z_stb(z_stb),
        .out_z(out_z), .out_z_stb(out_z_stb), .out_z_ack(out_z_ack),
        .level(level), .full(full), .empty(empty), .overflow(overflow),
        .drop_count(drop_count), .nan_seen(nan_seen)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Reference model: contents as a queue, flags as plain variables.
    logic [31:0] mq[$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_drop = 16'd0;
    logic        m_nan = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 16'd0;
            m_nan  = 1'b0;
        end else begin
            bit was_full;
            bit pop_m;
            was_full = (mq.size() == DEPTH);
            pop_m    = out_z_ack && (mq.size() > 0);
            if (pop_m) void'(mq.pop_front());
            if (z_stb) begin
                if (!was_full || pop_m) begin
                    mq.push_back(z);
                    if (z[30:23] == 8'hFF && z[22:0] != 23'd0) m_nan = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic [31:0] ez;
            int          n;
            n  = mq.size();
            ez = (n > 0) ? mq[0] : 32'h0;
            total++;
            if (out_z !== ez || out_z_stb !== (n > 0) || int'(level) != n ||
                full !== (n == DEPTH) || empty !== (n == 0) || overflow !== m_ovf ||
                drop_count !== m_drop || nan_seen !== m_nan) begin
                bad++;
                $display("FAIL model t=%0t out_z=%h/%h stb=%0b level=%0d/%0d ovf=%0b/%0b drop=%0d/%0d nan=%0b/%0b",
                         $time, out_z, ez, out_z_stb, level, n, overflow, m_ovf,
                         drop_count, m_drop, nan_seen, m_nan);
            end
        end
    end

    logic [31:0] got[$];
    logic [31:0] sent[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic [31:0] v, input logic a);
        z_stb = s;
        z = v;
        out_z_ack = a;
        if (out_z_stb && a) got.push_back(out_z);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        z_stb = 1'b0;
        out_z_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_stb"}, 32'(out_z_stb), 32'd0);
        chk({tag, "_outz"}, out_z, 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_drop"}, 32'(drop_count), 32'd0);
        chk({tag, "_nan"}, 32'(nan_seen), 32'd0);
    endtask

    initial begin
        do_reset();
        check_en = 1'b1;
        chk_reset_vals("reset");

        // Idle with ack while empty must not move anything.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b1);
            chk("idle_level", 32'(level), 32'd0);
            chk("idle_outz", out_z, 32'h0);
        end

        // Single word
        step(1'b1, 32'h3F800000, 1'b0);
        chk("single_outz", out_z, 32'h3F800000);
        chk("single_stb", 32'(out_z_stb), 32'd1);
        chk("single_level", 32'(level), 32'd1);
        step(1'b0, 32'h0, 1'b1);
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_outz0", out_z, 32'h0);

        // Fill and overflow
        for (int i = 1; i <= 18; i++) step(1'b1, 32'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd16);
        chk("fill_ovf", 32'(overflow), 32'd1);
        chk("fill_drop", 32'(drop_count), 32'd2);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_order", out_z, 32'(i));
            step(1'b0, 32'h0, 1'b1);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 16; i++) step(1'b1, 32'(i), 1'b0);
        chk("fp_head", out_z, 32'h1);
        step(1'b1, 32'hAA, 1'b1);
        chk("fp_level", 32'(level), 32'd16);
        chk("fp_drop", 32'(drop_count), 32'd2);
        for (int i = 0; i < 16; i++) begin
            chk("fp_order", out_z, (i == 15) ? 32'hAA : 32'(i + 2));
            step(1'b0, 32'h0, 1'b1);
        end
        chk("fp_empty", 32'(empty), 32'd1);

        // Wrap-around streaming: 40 words, ack alternating.
        do_reset();
        got.delete();
        sent.delete();
        for (int i = 0; i < 80; i++) begin
            logic [31:0] v;
            v = $urandom;
            if (i % 2 == 0) sent.push_back(v);
            step(i % 2 == 0, v, i % 2 == 1);
            chk("stream_level_le1", 32'(level <= 1), 32'd1);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
        chk("stream_count", 32'(got.size()), 32'd40);
        begin
            int first_bad;
            first_bad = -1;
            for (int i = 0; i < 40 && i < got.size(); i++)
                if (first_bad < 0 && got[i] !== sent[i]) first_bad = i;
            chk("stream_seq_first_bad_idx", 32'(first_bad), 32'hFFFFFFFF);
        end
        chk("stream_drop", 32'(drop_count), 32'd0);

        // Dropped NaN must not set the flag.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 32'h3F800000, 1'b0);
        step(1'b1, 32'h7FC00001, 1'b0);
        chk("dropnan_nan", 32'(nan_seen), 32'd0);
        chk("dropnan_drop", 32'(drop_count), 32'd1);

        // Infinity vs NaN, then reset mid-stream.
        do_reset();
        step(1'b1, 32'h7F800000, 1'b0);
        chk("inf_nan", 32'(nan_seen), 32'd0);
        step(1'b1, 32'h7FC00000, 1'b0);
        chk("nan_set", 32'(nan_seen), 32'd1);
        step(1'b1, 32'h7F800000, 1'b0);
        chk("nan_hold", 32'(nan_seen), 32'd1);
        step(1'b1, 32'h12345678, 1'b1);
        chk("pre_rst_level", 32'(level), 32'd3);
        rst = 1'b1;
        step(1'b1, 32'hDEADBEEF, 1'b1);
        rst = 1'b0;
        chk_reset_vals("midrst");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b1);
            chk("postrst_empty", 32'(empty), 32'd1);
        end

        // Random phase, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] v;
            logic        s, a;
            int          sel;
            sel = $urandom_range(0, 9);
            v = $urandom;
            if (sel == 0) v = {v[31], 8'hFF, v[22:1], 1'b1};
            else if (sel == 1) v = {v[31], 8'hFF, 23'd0};
            s = ($urandom_range(0, 3) != 0);
            case ((i / 500) % 4)
                0: a = ($urandom_range(0, 3) == 0);
                1: a = ($urandom_range(0, 3) != 0);
                2: a = 1'b1;
                default: a = ($urandom_range(0, 1) == 0);
            endcase
            rst = ($urandom_range(0, 599) == 0);
            step(s, v, a);
        end
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_result_fifo.md
# mul_result_fifo

Result buffer sitting directly downstream of the three-stage FP32 multiplier pipeline. The multiplier emits one IEEE-754 single-precision product per cycle with a valid strobe and no backpressure. This block absorbs that stream into a first-word-fall-through FIFO and presents it to the consumer (file writer, next PC node) over a stb/ack handshake. It also tracks dropped words and NaN products.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- LOG2_DEPTH, 4, log2(DEPTH)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- z  input  32  product from multiplier (FP32)
- z_stb  input  1  z valid this cycle; no ack returned, source never stalls
- out_z  output  32  head-of-FIFO word; 32'h0 when empty
- out_z_stb  output  1  out_z valid (FIFO non-empty)
- out_z_ack  input  1  consumer accepts out_z this cycle
- level  output  LOG2_DEPTH+1  current occupancy, 0..DEPTH
- full  output  1  level == DEPTH
- empty  output  1  level == 0
- overflow  output  1  sticky: at least one z_stb word dropped
- drop_count  output  16  number of dropped words, saturating
- nan_seen  output  1  sticky: an accepted word was a NaN

## Operation
- Storage: DEPTH x 32 array, write pointer wp and read pointer rp (LOG2_DEPTH bits, wrap modulo DEPTH), occupancy counter level.
- Push condition: push = z_stb & (~full | pop). Pop condition: pop = out_z_stb & out_z_ack.
- When full and pop happen together, the incoming word is accepted; level stays DEPTH.
- On push: mem[wp] <= z; wp <= wp+1 (wraps DEPTH-1 -> 0).
- On pop: rp <= rp+1 (wraps).
- Level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Drop: z_stb & full & ~pop. Sets overflow to 1 and increments drop_count. drop_count holds at 16'hFFFF.
- NaN detect on accepted words only: z[30:23] == 8'hFF and z[22:0] != 0 sets nan_seen. Infinities do not set it. Dropped NaNs do not set it.
- out_z_ack while empty is ignored; no pointer or level change.
- Order is strict FIFO; words are never reordered or duplicated.
- Reset mid-operation discards all contents. Sticky flags and drop_count clear only on rst.

## Timing
- Reset values (cycle after rst sampled high): wp = rp = 0, level = 0, empty = 1, full = 0, out_z_stb = 0, out_z = 32'h0, overflow = 0, drop_count = 0, nan_seen = 0.
- Memory contents are not reset. out_z is gated to 0 while empty.
- empty, full, out_z_stb and out_z are derived from registered state (level, rp, mem). They change only after a clock edge.
- Write-to-output latency: a word pushed at edge N appears on out_z with out_z_stb = 1 after edge N. The consumer can accept it at edge N+1.
- No combinational path from z/z_stb to out_z/out_z_stb.
- Consumer throughput: one pop per cycle while non-empty. With out_z_ack held high, the FIFO streams at the multiplier rate with level ≤ 1.
- overflow, drop_count and nan_seen update at the same edge as the drop or accept event.
- rst has priority over push and pop in the same cycle.

## Test plan
- Reset then idle: all outputs at reset values for 10 cycles. out_z_ack = 1 with empty FIFO changes nothing.
- Single word: z = 32'h3F800000 with z_stb for one cycle, out_z_ack = 0. Next cycle out_z = 32'h3F800000, out_z_stb = 1, level = 1. Pulsing ack once gives empty = 1 and out_z = 0.
- Fill and overflow: out_z_ack = 0, push 18 words 0x00000001..0x00000012. Required: full = 1, level = 16, overflow = 1, drop_count = 2. Draining yields 0x01..0x10 in order.
- Full with simultaneous push/pop: FIFO full with head 0x01, then z_stb and out_z_ack in the same cycle with z = 0xAA. Required: level stays 16, no drop. The final word drained is 0xAA.
- Wrap-around streaming: 40 consecutive words with out_z_ack toggling 1/0. Output sequence equals input sequence, drop_count = 0, and both pointers wrap at least twice.
- NaN and reset: push 32'h7FC00000 and nan_seen = 1; push 32'h7F800000 and the flag is unchanged. Assert rst mid-stream: next cycle all reset values, and previously queued words never appear.
